prbs_serial_pattern_gen: RTL and testbench

PRBS_SERIAL_PATTERN_GEN -- requirements
Module: prbs_serial_pattern_gen

---
 rtl/prbs_serial_pattern_gen.sv | 114 +++++++++++
 tb/tb_prbs_serial_pattern_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs_serial_pattern_gen.sv
// Serial pattern generator: each word is a PRBS7/15/31 or fixed word, built in one
// cycle and shifted out LSB first. It supports single-bit error injection.
module prbs_serial_pattern_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] fixed_word,
  input  logic             inj_err,
  output logic             data_out,
  output logic             word_start,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [30:0]      lfsr;
  logic [1:0]       mode_q;
  logic             pend;

  logic [30:0]      lfsr_src;
  logic [30:0]      lfsr_walk;
  logic [30:0]      lfsr_next;
  logic [WIDTH-1:0] prbs_word;
  logic [WIDTH-1:0] load_word;
  logic             flip;

  function automatic logic [30:0] seed_of(input logic [1:0] m);
    case (m)
      2'd0:    return 31'h0000_007F;
      2'd1:    return 31'h0000_7FFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic lfsr_dead(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return (s[6:0] == 7'd0);
      2'd1:    return (s[14:0] == 15'd0);
      default: return (s == 31'd0);
    endcase
  endfunction

  // One Fibonacci step; the feedback bit lands in bit 0 and is the output bit.
  function automatic logic [30:0] lfsr_step(input logic [30:0] s, input logic [1:0] m);
    logic fb;
    case (m)
      2'd0:    fb = s[6] ^ s[5];
      2'd1:    fb = s[14] ^ s[13];
      default: fb = s[30] ^ s[27];
    endcase
    return {s[29:0], fb};
  endfunction

  always_comb begin
    lfsr_src = lfsr;
    if ((mode != mode_q) || lfsr_dead(lfsr, mode)) begin
      lfsr_src = seed_of(mode);
    end
    lfsr_walk = lfsr_src;
    prbs_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lfsr_walk    = lfsr_step(lfsr_walk, mode);
      prbs_word[i] = lfsr_walk[0];
    end
    if (mode == 2'd3) begin
      load_word = fixed_word;
      lfsr_next = lfsr;
    end else begin
      load_word = prbs_word;
      lfsr_next = lfsr_walk;
    end
    flip = pend | inj_err;
  end

  // Output stage: word load at cnt=0, otherwise shift out the latched word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sr         <= '0;
      lfsr       <= '1;
      mode_q     <= 2'd0;
      pend       <= 1'b0;
      data_out   <= 1'b0;
      word_start <= 1'b0;
      word_cnt   <= '0;
    end else if (enable) begin
      pend <= 1'b0;
      if (cnt == '0) begin
        mode_q     <= mode;
        lfsr       <= lfsr_next;
        sr         <= load_word;
        data_out   <= load_word[0] ^ flip;
        word_start <= 1'b1;
        cnt        <= IDX_W'(1);
        word_cnt   <= word_cnt + CNT_W'(1);
      end else begin
        data_out   <= sr[cnt] ^ flip;
        word_start <= 1'b0;
        cnt        <= (cnt == LAST_IDX) ? '0 : cnt + IDX_W'(1);
      end
    end else begin
      pend       <= pend | inj_err;
      word_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prbs_serial_pattern_gen.sv
// Directed bench for prbs_serial_pattern_gen: hand-computed vectors plus a
// bit-serial reference LFSR for the longer PRBS streams.
module tb_prbs_serial_pattern_gen;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] fixed_word;
  logic             inj_err;
  logic             data_out;
  logic             word_start;
  logic [CNT_W-1:0] word_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [30:0]      m_s;
  logic [1:0]       m_mode;
  logic [WIDTH-1:0] m_fw;
  int               m_idx;
  logic [CNT_W-1:0] m_wc;
  logic             m_pend;
  logic             m_last;

  logic             hand7 [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic             handa5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  prbs_serial_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .fixed_word (fixed_word),
    .inj_err    (inj_err),
    .data_out   (data_out),
    .word_start (word_start),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset;
    m_s    = '1;
    m_mode = 2'd0;
    m_fw   = '0;
    m_idx  = 0;
    m_wc   = '0;
    m_pend = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic m_prbs(output logic b);
    case (m_mode)
      2'd0:    b = m_s[6] ^ m_s[5];
      2'd1:    b = m_s[14] ^ m_s[13];
      default: b = m_s[30] ^ m_s[27];
    endcase
    m_s = {m_s[29:0], b};
  endtask

  task automatic bit_step(input string tag);
    logic b;
    logic ws;
    ws = (m_idx == 0);
    if (ws) begin
      if (mode != m_mode) m_s = '1;
      m_mode = mode;
      m_fw   = fixed_word;
      m_wc   = m_wc + CNT_W'(1);
    end
    if (m_mode == 2'd3) b = m_fw[m_idx];
    else m_prbs(b);
    b      = b ^ (m_pend | inj_err);
    m_pend = 1'b0;
    m_last = b;
    m_idx  = (m_idx == WIDTH - 1) ? 0 : m_idx + 1;
    tick;
    chk({tag, "_bit"}, 64'(data_out), 64'(b));
    chk({tag, "_ws"}, 64'(word_start), 64'(ws));
    if (ws) chk({tag, "_wcnt"}, 64'(word_cnt), 64'(m_wc));
  endtask

  task automatic run_bits(input string tag, input int n);
    for (int i = 0; i < n; i++) bit_step($sformatf("%s[%0d]", tag, i));
  endtask

  task automatic hold_step(input string tag);
    m_pend = m_pend | inj_err;
    tick;
    chk({tag, "_bit"}, 64'(data_out), 64'(m_last));
    chk({tag, "_ws"}, 64'(word_start), 64'(0));
    chk({tag, "_wcnt"}, 64'(word_cnt), 64'(m_wc));
  endtask

  task automatic reset_step(input string tag);
    reset = 1'b1;
    tick;
    chk({tag, "_bit"}, 64'(data_out), 64'(0));
    chk({tag, "_ws"}, 64'(word_start), 64'(0));
    chk({tag, "_wcnt"}, 64'(word_cnt), 64'(0));
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    inj_err    = 1'b1;
    mode       = 2'd2;
    fixed_word = '1;
    for (int i = 0; i < 3; i++) reset_step($sformatf("rst[%0d]", i));

    // PRBS7 from reset: hand-computed first seven bits, then eight full words.
    reset   = 1'b0;
    inj_err = 1'b0;
    mode    = 2'd0;
    m_reset();
    for (int i = 0; i < 7; i++) begin
      bit_step($sformatf("p7_first[%0d]", i));
      chk($sformatf("p7_hand[%0d]", i), 64'(data_out), 64'(hand7[i]));
    end
    run_bits("p7", 8 * WIDTH - 7);
    chk("p7_words", 64'(word_cnt), 64'(8));

    // Mode change at bit 5 only takes effect at the next word.
    run_bits("sw_pre", 5);
    mode = 2'd1;
    run_bits("sw_post", WIDTH - 5);
    for (int i = 0; i < WIDTH; i++) begin
      bit_step($sformatf("p15[%0d]", i));
      if (i < 15) chk($sformatf("p15_hand[%0d]", i), 64'(data_out), 64'(i == 14));
    end

    // PRBS31 with a single injected error on bit 10 of word 3.
    mode = 2'd2;
    run_bits("p31", 3 * WIDTH);
    run_bits("p31_w3a", 10);
    inj_err = 1'b1;
    bit_step("p31_inj");
    inj_err = 1'b0;
    run_bits("p31_w3b", WIDTH - 11);

    // Freeze for 20 cycles after bit 0; two pulses while frozen make one inversion.
    bit_step("frz_b0");
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      inj_err = (i == 5 || i == 8);
      hold_step($sformatf("frz[%0d]", i));
    end
    inj_err = 1'b0;
    enable  = 1'b1;
    run_bits("frz_resume", WIDTH - 1);

    // Fixed word 0xA5; word counter wraps 15 -> 0 on the first load.
    mode       = 2'd3;
    fixed_word = 32'h0000_00A5;
    for (int i = 0; i < WIDTH; i++) begin
      bit_step($sformatf("fix[%0d]", i));
      chk($sformatf("fix_hand[%0d]", i), 64'(data_out), 64'(i < 8 ? handa5[i] : 1'b0));
      if (i == 0) chk("fix_wrap", 64'(word_cnt), 64'(0));
    end
    run_bits("fix2a", 3);
    fixed_word = 32'hFFFF_FFFF;
    for (int i = 3; i < WIDTH; i++) begin
      bit_step($sformatf("fix2[%0d]", i));
      chk($sformatf("fix2_hand[%0d]", i), 64'(data_out), 64'(i < 8 ? handa5[i] : 1'b0));
    end
    for (int i = 0; i < WIDTH; i++) begin
      bit_step($sformatf("ones[%0d]", i));
      chk($sformatf("ones_hand[%0d]", i), 64'(data_out), 64'(1));
    end

    // Back to PRBS7, reset at bit 17, then a fresh word from the seed.
    mode = 2'd0;
    run_bits("pre_rst", 17);
    inj_err = 1'b1;
    reset_step("mid_rst0");
    reset_step("mid_rst1");
    reset   = 1'b0;
    inj_err = 1'b0;
    m_reset();
    for (int i = 0; i < 7; i++) begin
      bit_step($sformatf("post_rst[%0d]", i));
      chk($sformatf("post_rst_hand[%0d]", i), 64'(data_out), 64'(hand7[i]));
      if (i == 0) chk("post_rst_wcnt", 64'(word_cnt), 64'(1));
    end
    run_bits("post_rst_rest", WIDTH - 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
